// File: rtl/cfg_watchdog_if.sv
// Control/status bundle between the config register block and the watchdog.
interface cfg_watchdog_if #(
   parameter int unsigned EXP_W = 8
) ();
   logic             heartbeat;
   logic [31:0]      div_factor;
   logic             cfg_we;
   logic             timeout;
   logic [EXP_W-1:0] expire_cnt;
   logic [1:0]       wdt_state;

   modport master (
      output heartbeat, div_factor, cfg_we,
      input  timeout, expire_cnt, wdt_state
   );

   modport slave (
      input  heartbeat, div_factor, cfg_we,
      output timeout, expire_cnt, wdt_state
   );
endinterface

// File: rtl/cfg_watchdog.sv
// Heartbeat watchdog: prescales clk by div_factor+1 into ticks and raises a
// sticky timeout after TIMEOUT_TICKS ticks without a heartbeat.
module cfg_watchdog #(
   parameter int unsigned TIMEOUT_TICKS = 16,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned EXP_W         = 8
) (
   input logic           clk,
   input logic           rst_n,
   cfg_watchdog_if.slave bus
);

   localparam int unsigned PRESC_W = 32;
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t             state;
   logic [PRESC_W-1:0] presc;
   logic [CNT_W-1:0]   window;
   logic               timeout_q;
   logic [EXP_W-1:0]   exp_q;

   // Heartbeat has priority over cfg_we and over an expiring tick. The
   // prescaler compare uses >= so a lowered div_factor ticks on the next clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         presc     <= '0;
         window    <= '0;
         timeout_q <= 1'b0;
         exp_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.heartbeat) begin
                  state  <= RUN;
                  presc  <= '0;
                  window <= '0;
               end
               timeout_q <= 1'b0;
            end
            RUN: begin
               if (bus.heartbeat) begin
                  presc  <= '0;
                  window <= '0;
               end else if (bus.cfg_we) begin
                  presc <= '0;
               end else if (presc >= bus.div_factor) begin
                  presc <= '0;
                  if (window == WIN_LAST) begin
                     state     <= EXPIRED;
                     timeout_q <= 1'b1;
                     if (exp_q != '1) exp_q <= exp_q + EXP_W'(1);
                  end else begin
                     window <= window + CNT_W'(1);
                  end
               end else begin
                  presc <= presc + PRESC_W'(1);
               end
            end
            EXPIRED: begin
               if (bus.heartbeat) begin
                  state     <= RUN;
                  presc     <= '0;
                  window    <= '0;
                  timeout_q <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               presc     <= '0;
               window    <= '0;
               timeout_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.timeout    = timeout_q;
   assign bus.expire_cnt = exp_q;
   assign bus.wdt_state  = state;

endmodule

// File: tb/tb_cfg_watchdog.sv
// Directed self-checking bench for cfg_watchdog.
module tb_cfg_watchdog;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   exp_model;

   cfg_watchdog_if #(.EXP_W(8)) wd_if ();

   cfg_watchdog #(
      .TIMEOUT_TICKS(16),
      .CNT_W        (16),
      .EXP_W        (8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (wd_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic kick();
      wd_if.heartbeat = 1'b1;
      step(1);
      wd_if.heartbeat = 1'b0;
   endtask

   task automatic test_reset();
      rst_n            = 1'b0;
      wd_if.heartbeat  = 1'b0;
      wd_if.cfg_we     = 1'b0;
      wd_if.div_factor = 32'd0;
      step(3);
      rst_n = 1'b1;
      step(1);
      for (int i = 0; i < 200; i++) begin
         checks++;
         if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd0 || wd_if.expire_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_idle clk=%0d timeout=%b state=%0d cnt=%0d required 0/0/0",
                     i, wd_if.timeout, wd_if.wdt_state, wd_if.expire_cnt);
         end
         step(1);
      end
   endtask

   task automatic test_expiry_div3();
      wd_if.div_factor = 32'd3;
      kick();
      step(63);
      checks++;
      if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd1) begin
         failures++;
         $display("FAIL div3_before_E64 timeout=%b state=%0d required 0/1", wd_if.timeout, wd_if.wdt_state);
      end
      step(1);
      exp_model = 1;
      checks++;
      if (wd_if.timeout !== 1'b1 || wd_if.wdt_state !== 2'd2 || wd_if.expire_cnt !== 8'(exp_model)) begin
         failures++;
         $display("FAIL div3_at_E64 timeout=%b state=%0d cnt=%0d required 1/2/%0d",
                  wd_if.timeout, wd_if.wdt_state, wd_if.expire_cnt, exp_model);
      end
   endtask

   task automatic test_kick_on_expiry();
      wd_if.div_factor = 32'd0;
      kick();
      step(15);
      checks++;
      if (wd_if.timeout !== 1'b0) begin
         failures++;
         $display("FAIL race_E15 timeout=%b required 0", wd_if.timeout);
      end
      kick();
      checks++;
      if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd1) begin
         failures++;
         $display("FAIL race_E16 timeout=%b state=%0d required 0/1", wd_if.timeout, wd_if.wdt_state);
      end
      step(15);
      checks++;
      if (wd_if.timeout !== 1'b0) begin
         failures++;
         $display("FAIL race_E31 timeout=%b required 0", wd_if.timeout);
      end
      step(1);
      exp_model++;
      checks++;
      if (wd_if.timeout !== 1'b1 || wd_if.expire_cnt !== 8'(exp_model)) begin
         failures++;
         $display("FAIL race_E32 timeout=%b cnt=%0d required 1/%0d", wd_if.timeout, wd_if.expire_cnt, exp_model);
      end
   endtask

   task automatic test_periodic_kick();
      wd_if.div_factor = 32'd0;
      for (int i = 0; i < 50; i++) begin
         kick();
         step(9);
         checks++;
         if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd1) begin
            failures++;
            $display("FAIL periodic_kick iter=%0d timeout=%b state=%0d required 0/1",
                     i, wd_if.timeout, wd_if.wdt_state);
         end
      end
   endtask

   task automatic test_live_div();
      wd_if.div_factor = 32'd7;
      kick();
      step(5);
      wd_if.div_factor = 32'd2;
      step(45);
      checks++;
      if (wd_if.timeout !== 1'b0) begin
         failures++;
         $display("FAIL live_div_E50 timeout=%b required 0", wd_if.timeout);
      end
      step(1);
      exp_model++;
      checks++;
      if (wd_if.timeout !== 1'b1 || wd_if.expire_cnt !== 8'(exp_model)) begin
         failures++;
         $display("FAIL live_div_E51 timeout=%b cnt=%0d required 1/%0d", wd_if.timeout, wd_if.expire_cnt, exp_model);
      end
   endtask

   task automatic test_saturation();
      wd_if.div_factor = 32'd0;
      for (int i = 0; i < 300; i++) begin
         kick();
         checks++;
         if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd1) begin
            failures++;
            $display("FAIL rearm iter=%0d timeout=%b state=%0d required 0/1", i, wd_if.timeout, wd_if.wdt_state);
         end
         step(16);
         if (exp_model < 255) exp_model++;
         checks++;
         if (wd_if.timeout !== 1'b1 || wd_if.wdt_state !== 2'd2 || wd_if.expire_cnt !== 8'(exp_model)) begin
            failures++;
            $display("FAIL reexpire iter=%0d timeout=%b state=%0d cnt=%0d required 1/2/%0d",
                     i, wd_if.timeout, wd_if.wdt_state, wd_if.expire_cnt, exp_model);
         end
      end
      checks++;
      if (wd_if.expire_cnt !== 8'd255) begin
         failures++;
         $display("FAIL saturate cnt=%0d required 255", wd_if.expire_cnt);
      end
   endtask

   task automatic test_cfg_we_and_reset();
      wd_if.div_factor = 32'd7;
      kick();
      for (int i = 0; i < 40; i++) begin
         wd_if.cfg_we = 1'b1;
         step(1);
         wd_if.cfg_we = 1'b0;
         step(4);
      end
      checks++;
      if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd1) begin
         failures++;
         $display("FAIL cfg_we_hold timeout=%b state=%0d required 0/1", wd_if.timeout, wd_if.wdt_state);
      end
      // Move the kicks aside and let the count run free, then reset mid-window
      step(50);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd0 || wd_if.expire_cnt !== 8'd0) begin
         failures++;
         $display("FAIL async_reset timeout=%b state=%0d cnt=%0d required 0/0/0",
                  wd_if.timeout, wd_if.wdt_state, wd_if.expire_cnt);
      end
      step(2);
      #3;
      rst_n = 1'b1;
      wd_if.div_factor = 32'd0;
      step(40);
      checks++;
      if (wd_if.timeout !== 1'b0 || wd_if.wdt_state !== 2'd0) begin
         failures++;
         $display("FAIL rearm_needed timeout=%b state=%0d required 0/0", wd_if.timeout, wd_if.wdt_state);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_model = 0;
      test_reset();
      test_expiry_div3();
      test_kick_on_expiry();
      test_periodic_kick();
      test_live_div();
      test_saturation();
      test_cfg_we_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
